// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32 width codes, FSM states
// and the access legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // True when the access must complete as a fault without touching memory.
    function automatic logic access_fault(input logic       load,
                                          input logic       store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic legal;
        legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                (funct3 == F3_BU) || (funct3 == F3_HU);
        return (load && store) || !legal || (store && funct3[2]) ||
               ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3 == F3_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and data replication,
// plus load lane extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_addr_lo_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  req_ben_o,
    output logic [31:0] req_wdata_o,
    input  logic [2:0]  resp_funct3_i,
    input  logic [1:0]  resp_addr_lo_i,
    input  logic [31:0] resp_rdata_i,
    output logic [31:0] resp_rdata_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        req_ben_o   = 4'b1111;
        req_wdata_o = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                req_ben_o   = 4'b0001 << req_addr_lo_i;
                req_wdata_o = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                req_ben_o   = 4'b0011 << {req_addr_lo_i[1], 1'b0};
                req_wdata_o = {2{req_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_b = resp_rdata_i[7:0];
        case (resp_addr_lo_i)
            2'd1:    lane_b = resp_rdata_i[15:8];
            2'd2:    lane_b = resp_rdata_i[23:16];
            2'd3:    lane_b = resp_rdata_i[31:24];
            default: ;
        endcase
        lane_h = resp_addr_lo_i[1] ? resp_rdata_i[31:16] : resp_rdata_i[15:0];
        case (resp_funct3_i)
            F3_B:    resp_rdata_o = {{24{lane_b[7]}}, lane_b};
            F3_H:    resp_rdata_o = {{16{lane_h[15]}}, lane_h};
            F3_BU:   resp_rdata_o = {24'b0, lane_b};
            F3_HU:   resp_rdata_o = {16'b0, lane_h};
            default: resp_rdata_o = resp_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of main_mem's data port: accepts one access from
// execute, issues a word request, waits for ready and returns extended data.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic          i_load,
    input  logic          i_store,
    input  logic [2:0]    i_funct3,
    input  logic [31:0]   i_addr,
    input  logic [31:0]   i_wdata,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_fault,
    output logic [31:0]   o_rdata,
    output logic          o_dm_ren,
    output logic          o_dm_wen,
    output logic [3:0]    o_dm_ben,
    output logic [AW-1:0] o_dm_addr,
    output logic [31:0]   o_dm_wdata,
    input  logic [31:0]   i_dm_rdata,
    input  logic          i_dm_ready
);

    state_t        state_q, state_d;
    logic          ren_q, ren_d, wen_q, wen_d;
    logic [3:0]    ben_q, ben_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    lo_q, lo_d;
    logic          done_q, done_d, fault_q, fault_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [3:0]    req_ben;
    logic [31:0]   req_wdata, load_data;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^i_addr[31:AW+2];

    lsu_align u_align (
        .req_size_i     (i_funct3[1:0]),
        .req_addr_lo_i  (i_addr[1:0]),
        .req_wdata_i    (i_wdata),
        .req_ben_o      (req_ben),
        .req_wdata_o    (req_wdata),
        .resp_funct3_i  (f3_q),
        .resp_addr_lo_i (lo_q),
        .resp_rdata_i   (i_dm_rdata),
        .resp_rdata_o   (load_data)
    );

    always_comb begin
        state_d = state_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        ben_d   = ben_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                // Both strobes low is a bubble from execute, not an access.
                if (i_valid && (i_load || i_store)) begin
                    if (access_fault(i_load, i_store, i_funct3, i_addr[1:0])) begin
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        ren_d   = i_load;
                        wen_d   = i_store;
                        ben_d   = req_ben;
                        addr_d  = i_addr[AW+1:2];
                        wdata_d = req_wdata;
                        f3_d    = i_funct3;
                        lo_d    = i_addr[1:0];
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (i_dm_ready) begin
                    ren_d = 1'b0;
                    wen_d = 1'b0;
                    if (wen_q) begin
                        done_d  = 1'b1;
                        rdata_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                rdata_d = load_data;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        // NOTE: data registers are reset too, because every output, not just control, must read 0 after reset.
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            ben_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            ben_q   <= ben_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = done_q;
    assign o_fault    = fault_q;
    assign o_rdata    = rdata_q;
    assign o_dm_ren   = ren_q;
    assign o_dm_wen   = wen_q;
    assign o_dm_ben   = ben_q;
    assign o_dm_addr  = addr_q;
    assign o_dm_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a small byte-enabled word memory standing in for main_mem.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, load, store;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        busy, done, fault;
    logic [31:0] rdata;
    logic        dm_ren, dm_wen;
    logic [3:0]  dm_ben;
    logic [13:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata = '0;
    logic        dm_ready;
    logic [31:0] mem [16] = '{default: 32'h0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_lsu #(.AW(14)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_load     (load),
        .i_store    (store),
        .i_funct3   (f3),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .o_busy     (busy),
        .o_done     (done),
        .o_fault    (fault),
        .o_rdata    (rdata),
        .o_dm_ren   (dm_ren),
        .o_dm_wen   (dm_wen),
        .o_dm_ben   (dm_ben),
        .o_dm_addr  (dm_addr),
        .o_dm_wdata (dm_wdata),
        .i_dm_rdata (dm_rdata),
        .i_dm_ready (dm_ready)
    );

    // main_mem stand-in: writes and registered reads happen on a ready edge.
    always @(posedge clk) begin
        if (dm_wen && dm_ready)
            for (int i = 0; i < 4; i++)
                if (dm_ben[i]) mem[dm_addr[3:0]][8*i +: 8] <= dm_wdata[8*i +: 8];
        if (dm_ren && dm_ready) dm_rdata <= mem[dm_addr[3:0]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        valid = 1'b0;
        load  = 1'b0;
        store = 1'b0;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1;
        load  = ld;
        store = st;
        f3    = f;
        addr  = a;
        wdata = d;
    endtask

    // Presents one access for a single edge; returns in the cycle after acceptance.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        drive(ld, st, f, a, d);
        tick;
        idle_in;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_in;
        f3 = 3'b000; addr = '0; wdata = '0; dm_ready = 1'b1;
        tick;
        tick;
        checks++;
        if ({busy, done, fault, dm_ren, dm_wen, dm_ben} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want %b", {busy, done, fault, dm_ren, dm_wen, dm_ben}, 9'b0);
        end
        checks++;
        if ({dm_addr, dm_wdata, rdata} !== 78'b0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h want 0", dm_addr, dm_wdata, rdata);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_sw;
        issue(1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF);
        checks++;
        if ({busy, dm_wen, dm_ren, dm_ben, done} !== 8'b1_1_0_1111_0) begin
            errors++;
            $display("FAIL sw_req got %b want %b", {busy, dm_wen, dm_ren, dm_ben, done}, 8'b1_1_0_1111_0);
        end
        checks++;
        if (dm_addr !== 14'h401) begin
            errors++;
            $display("FAIL sw_addr got %h want %h", dm_addr, 14'h401);
        end
        checks++;
        if (dm_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_wdata got %h want %h", dm_wdata, 32'hDEAD_BEEF);
        end
        tick;
        checks++;
        if ({done, fault, busy, dm_wen} !== 4'b1000) begin
            errors++;
            $display("FAIL sw_done got %b want %b", {done, fault, busy, dm_wen}, 4'b1000);
        end
        tick;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL sw_pulse got %b want 0", done);
        end
    endtask

    task automatic test_sb_lb;
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5);
        checks++;
        if ({dm_wen, dm_ben, dm_wdata} !== {1'b1, 4'b1000, 32'hA5A5_A5A5}) begin
            errors++;
            $display("FAIL sb_req got %b %b %h want 1 1000 a5a5a5a5", dm_wen, dm_ben, dm_wdata);
        end
        tick;
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0003, 32'h0);
        checks++;
        if ({dm_ren, dm_wen, dm_ben, dm_addr} !== {1'b1, 1'b0, 4'b1000, 14'h0}) begin
            errors++;
            $display("FAIL lb_req got %b %b %b %h want 1 0 1000 0", dm_ren, dm_wen, dm_ben, dm_addr);
        end
        tick;
        checks++;
        if ({busy, done, dm_ren} !== 3'b100) begin
            errors++;
            $display("FAIL lb_resp got %b want 100", {busy, done, dm_ren});
        end
        tick;
        checks++;
        if ({done, fault, rdata} !== {2'b10, 32'hFFFF_FFA5}) begin
            errors++;
            $display("FAIL lb_data got %b %b %h want 1 0 ffffffa5", done, fault, rdata);
        end
        tick;
        checks++;
        if ({done, rdata} !== {1'b0, 32'hFFFF_FFA5}) begin
            errors++;
            $display("FAIL lb_hold got %b %h want 0 ffffffa5", done, rdata);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  lf [7] = '{3'b101, 3'b001, 3'b001, 3'b000, 3'b100, 3'b000, 3'b010};
        logic [31:0] la [7] = '{32'h6, 32'h6, 32'h4, 32'h4, 32'h5, 32'h7, 32'h4};
        logic [3:0]  lb [7] = '{4'b1100, 4'b1100, 4'b0011, 4'b0001, 4'b0010, 4'b1000, 4'b1111};
        logic [31:0] lx [7] = '{32'h0000_8001, 32'hFFFF_8001, 32'h0000_7FFF, 32'hFFFF_FFFF,
                                32'h0000_007F, 32'hFFFF_FF80, 32'h8001_7FFF};
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0004, 32'h8001_7FFF);
        tick;
        checks++;
        if ({done, rdata} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL sw4_done got %b %h want 1 00000000", done, rdata);
        end
        for (int i = 0; i < 7; i++) begin
            issue(1'b1, 1'b0, lf[i], la[i], 32'h0);
            checks++;
            if ({dm_ren, dm_ben, dm_addr} !== {1'b1, lb[i], 14'h1}) begin
                errors++;
                $display("FAIL load%0d_req got %b %b %h want 1 %b 1", i, dm_ren, dm_ben, dm_addr, lb[i]);
            end
            tick;
            tick;
            checks++;
            if ({done, rdata} !== {1'b1, lx[i]}) begin
                errors++;
                $display("FAIL load%0d_data got %b %h want 1 %h", i, done, rdata, lx[i]);
            end
        end
    endtask

    task automatic test_fault;
        logic        fl [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        logic        fs [9] = '{0, 0, 1, 1, 1, 0, 0, 1, 0};
        logic [2:0]  ff [9] = '{3'b010, 3'b011, 3'b010, 3'b001, 3'b100, 3'b001, 3'b101, 3'b000, 3'b110};
        logic [31:0] fa [9] = '{32'h2, 32'h0, 32'h1, 32'h3, 32'h0, 32'h1, 32'h5, 32'h0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            issue(fl[i], fs[i], ff[i], fa[i], 32'h1234_5678);
            checks++;
            if ({done, fault, busy, dm_ren, dm_wen, rdata} !== {5'b11000, 32'h0}) begin
                errors++;
                $display("FAIL fault%0d got %b %h want 11000 00000000", i, {done, fault, busy, dm_ren, dm_wen}, rdata);
            end
            tick;
            checks++;
            if ({done, fault, dm_ren, dm_wen} !== 4'b0000) begin
                errors++;
                $display("FAIL fault%0d_pulse got %b want 0000", i, {done, fault, dm_ren, dm_wen});
            end
        end
        issue(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        checks++;
        if ({done, fault, busy, dm_ren, dm_wen} !== 5'b00000) begin
            errors++;
            $display("FAIL noop got %b want 00000", {done, fault, busy, dm_ren, dm_wen});
        end
    endtask

    task automatic test_stall;
        dm_ready = 1'b0;
        issue(1'b0, 1'b1, 3'b001, 32'h0000_000A, 32'h0000_1234);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({busy, dm_wen, dm_ren, dm_ben, dm_addr, dm_wdata, done} !==
                {3'b110, 4'b1100, 14'h2, 32'h1234_1234, 1'b0}) begin
                errors++;
                $display("FAIL stall%0d got %b %b %b %b %h %h %b", k, busy, dm_wen, dm_ren, dm_ben, dm_addr, dm_wdata, done);
            end
            if (k == 1) drive(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
            if (k == 5) begin
                idle_in;
                dm_ready = 1'b1;
            end
            tick;
        end
        checks++;
        if ({done, busy, dm_wen, dm_ren} !== 4'b1000) begin
            errors++;
            $display("FAIL stall_done got %b want 1000", {done, busy, dm_wen, dm_ren});
        end
        tick;
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 1'b1, 3'b000, 32'h0000_0008, 32'h0000_005A);
        tick;
        drive(1'b1, 1'b0, 3'b100, 32'h0000_0008, 32'h0);
        checks++;
        if ({dm_wen, dm_ben, dm_addr, dm_wdata} !== {1'b1, 4'b0001, 14'h2, 32'h5A5A_5A5A}) begin
            errors++;
            $display("FAIL b2b_sb got %b %b %h %h", dm_wen, dm_ben, dm_addr, dm_wdata);
        end
        tick;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_done got %b want 10", {done, busy});
        end
        tick;
        idle_in;
        checks++;
        if ({busy, dm_ren, dm_wen, dm_ben, dm_addr, done} !== {3'b110, 4'b0001, 14'h2, 1'b0}) begin
            errors++;
            $display("FAIL b2b_lbu_req got %b %b %b %b %h %b", busy, dm_ren, dm_wen, dm_ben, dm_addr, done);
        end
        tick;
        tick;
        checks++;
        if ({done, rdata} !== {1'b1, 32'h0000_005A}) begin
            errors++;
            $display("FAIL b2b_lbu_data got %b %h want 1 0000005a", done, rdata);
        end
        tick;
    endtask

    task automatic test_reset_resp;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'h0);
        tick;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL rst_resp_pre got %b want 10", {busy, done});
        end
        rst_n = 1'b0;
        tick;
        checks++;
        if ({busy, done, fault, dm_ren, dm_wen, dm_ben, dm_addr, dm_wdata, rdata} !== 87'b0) begin
            errors++;
            $display("FAIL rst_resp got %b %h %h %h want 0", {busy, done, fault, dm_ren, dm_wen, dm_ben}, dm_addr, dm_wdata, rdata);
        end
        rst_n = 1'b1;
        tick;
        checks++;
        if ({busy, done, rdata} !== 34'b0) begin
            errors++;
            $display("FAIL rst_resp_after got %b %b %h want 0 0 0", busy, done, rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_sw;
        test_sb_lb;
        test_loads;
        test_fault;
        test_stall;
        test_back_to_back;
        test_reset_resp;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
